gray2bin_arb: RTL and testbench
===============================

# gray2bin_arb

Round-robin arbiter and sequencer that shares one Gray-to-binary converter between `N_REQ` requesters. It latches a requester's Gray word and issues a one-cycle `init` to the converter. It then waits for the converter's `done`, bounded by a watchdog, and returns the binary result with a one-cycle acknowledge. The block sits between requesters (e.g. async-FIFO pointer consumers) and a single converter, which may be registered or combinational.

## Interface
- `WIDTH`, 8: data width of Gray/binary words.
- `N_REQ`, 4: number of requesters, ≥2.
- `TIMEOUT`, 15: maximum cycles spent in WAIT before an error response, ≥1.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  N_REQ  level request per requester; held until its `ack_o` bit.
- `req_data_i`  in  N_REQ*WIDTH  Gray words; requester k at `[k*WIDTH +: WIDTH]`.
- `gnt_o`  out  N_REQ  one-hot current owner; held from ISSUE through RESP, else 0.
- `ack_o`  out  N_REQ  one-hot, 1-cycle completion pulse to the owner.
- `err_o`  out  1  with `ack_o`: 1 means watchdog expired and `rsp_data_o` is 0.
- `rsp_data_o`  out  WIDTH  binary result; valid with `ack_o`, holds until the next response.
- `busy_o`  out  1  high in any state other than IDLE.
- `conv_init_o`  out  1  converter start; exactly one cycle per transaction.
- `conv_data_o`  out  WIDTH  latched Gray word of the owner; stable from ISSUE through RESP.
- `conv_done_i`  in  1  converter completion.
- `conv_data_i`  in  WIDTH  converter binary output; sampled when `conv_done_i` is high.

## Operation
- States are IDLE, ISSUE, WAIT and RESP; reset enters IDLE.
- **IDLE:** if any `req_i` bit is high, select the winner by round-robin. Search starts at `last+1` modulo `N_REQ`. Register `gnt_o`, latch the winner's word into `conv_data_o`, then go to ISSUE. With no request, stay in IDLE.
- **ISSUE:** `conv_init_o`=1.
  - `conv_done_i`=1 in the same cycle (combinational converter): capture `conv_data_i` and go to RESP.
  - Otherwise go to WAIT and clear the watchdog counter.
- **WAIT:** when `conv_done_i`=1, capture `conv_data_i` and go to RESP. Otherwise, once the counter reaches `TIMEOUT-1`, set the error flag, capture 0 and go to RESP. Otherwise increment the counter.
- **RESP:** drive `ack_o`=`gnt_o`, `err_o`=error flag and `rsp_data_o`=captured value. Set `last`=owner index, then go to IDLE and clear `gnt_o`.
- The counter is `$clog2(TIMEOUT+1)` bits and saturates, never wraps.
- Fairness: a requester that is continuously asserted is served within `N_REQ` transactions.
- `conv_done_i` is ignored in IDLE and RESP. A late `done` after a timeout is dropped.
- `req_i` is sampled only in IDLE. Deasserting `req_i` after grant is a protocol violation; the transaction still completes and acks.
- Simultaneous requests: exactly one is granted; the others stay pending, with no loss.

## Timing
- Reset values: `gnt_o`, `ack_o`, `err_o`, `rsp_data_o`, `busy_o`, `conv_init_o`, `conv_data_o` all 0. State is IDLE, the counter is 0, and `last`=N_REQ-1 so requester 0 has first priority.
- Take cycle 0 as `req_i` seen in IDLE.
  - ISSUE (`conv_init_o`=1, `gnt_o` valid) is cycle 1.
  - Combinational converter: `ack_o` in cycle 2.
  - Converter with done L cycles after init: `ack_o` in cycle 2+L.
- Timeout: WAIT occupies cycles 2..TIMEOUT+1 and the error `ack_o` comes in cycle TIMEOUT+2.
- Back-to-back: the next IDLE arbitration happens in the cycle after RESP. Minimum transaction period is 3 cycles for a combinational converter, 4 for a registered one.
- All outputs are registered or decoded from registered state; there is no combinational path from `req_i` to any output.
- Reset asserted mid-transaction: all outputs go to 0 immediately (asynchronously), any pending `ack_o` is lost, and `last` is reset.

## Test plan
- **Single request, registered converter:** `req_i`=0010, word k=1 = 0xB6, `done` one cycle after init. Expect `gnt_o`=0010 and `conv_init_o` in cycle 1, then `ack_o`=0010, `rsp_data_o`=0xDB, `err_o`=0 in cycle 3.
- **Same request, combinational converter:** `done` in the init cycle. Expect `ack_o` in cycle 2 and `rsp_data_o`=0xDB.
- **All four requesters held high:** words 0x00, 0x01, 0x03, 0x02. Expect grant order 0,1,2,3,0 with results 0x00, 0x01, 0x02, 0x03, and exactly one `conv_init_o` per transaction.
- **Watchdog:** `TIMEOUT`=15, converter silent. Expect `ack_o` in cycle 17 with `err_o`=1 and `rsp_data_o`=0. A `done` injected in cycle 18 is ignored and `busy_o` is 0.
- **Reset mid-WAIT:** pull `rst_n_i` low in cycle 2. All outputs go to 0 at once with no `ack_o`. After release, `req_i`=1001 grants requester 0 first.
- **Spurious done in IDLE:** `conv_done_i`=1 with no request. Expect no `ack_o`, `busy_o`=0, and `rsp_data_o` unchanged.

Source files
------------

// File: rtl/gray2bin_arb.sv
`default_nettype none
// ============================================================================
// gray2bin_arb : round-robin arbiter/sequencer sharing one Gray-to-binary
//                converter between N_REQ requesters, with a WAIT watchdog.
// Revision     : 1.0
// ============================================================================
module gray2bin_arb #(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       ack_o,
  output logic                   err_o,
  output logic [WIDTH-1:0]       rsp_data_o,
  output logic                   busy_o,
  output logic                   conv_init_o,
  output logic [WIDTH-1:0]       conv_data_o,
  input  logic                   conv_done_i,
  input  logic [WIDTH-1:0]       conv_data_i
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  win;
  logic              found;
  logic [CNT_W-1:0]  cnt;

  // Index of the requester 'off+1' positions after 'base', wrapping at N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off + 1;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    win   = last;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[rr_pick(last, i)]) begin
        found = 1'b1;
        win   = rr_pick(last, i);
      end
    end
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      last        <= IDX_W'(N_REQ - 1);
      owner       <= '0;
      cnt         <= '0;
      gnt_o       <= '0;
      ack_o       <= '0;
      err_o       <= 1'b0;
      rsp_data_o  <= '0;
      conv_init_o <= 1'b0;
      conv_data_o <= '0;
    end else begin
      ack_o       <= '0;
      err_o       <= 1'b0;
      conv_init_o <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state       <= ISSUE;
            owner       <= win;
            gnt_o       <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            conv_data_o <= req_data_i[int'(win)*WIDTH +: WIDTH];
            conv_init_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (conv_done_i) begin
            state      <= RESP;
            ack_o      <= gnt_o;
            rsp_data_o <= conv_data_i;
          end else begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (conv_done_i) begin
            state      <= RESP;
            ack_o      <= gnt_o;
            rsp_data_o <= conv_data_i;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state      <= RESP;
            ack_o      <= gnt_o;
            err_o      <= 1'b1;
            rsp_data_o <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          gnt_o <= '0;
          last  <= owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray2bin_arb.sv
`default_nettype none
// ============================================================================
// tb_gray2bin_arb : directed self-checking bench for gray2bin_arb.
// Revision        : 1.0
// ============================================================================
module tb_gray2bin_arb;

  localparam int WIDTH   = 8;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 15;

  logic                   clk_i = 1'b0;
  logic                   rst_n_i;
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       gnt_o;
  logic [N_REQ-1:0]       ack_o;
  logic                   err_o;
  logic [WIDTH-1:0]       rsp_data_o;
  logic                   busy_o;
  logic                   conv_init_o;
  logic [WIDTH-1:0]       conv_data_o;
  logic                   conv_done_i;
  logic [WIDTH-1:0]       conv_data_i;

  // Converter model: 0 = silent, 1 = combinational, 2 = registered (L=1)
  logic [1:0] mode;
  logic       force_done;
  logic       init_d;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  gray2bin_arb #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .gnt_o       (gnt_o),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .rsp_data_o  (rsp_data_o),
    .busy_o      (busy_o),
    .conv_init_o (conv_init_o),
    .conv_data_o (conv_data_o),
    .conv_done_i (conv_done_i),
    .conv_data_i (conv_data_i)
  );

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    for (int i = 0; i < WIDTH; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) init_d <= 1'b0;
    else          init_d <= conv_init_o;
  end

  assign conv_done_i = force_done | ((mode == 2'd1) & conv_init_o) | ((mode == 2'd2) & init_d);
  assign conv_data_i = force_done ? 8'h5A : g2b(conv_data_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_own [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] exp_rsp [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};

  initial begin
    int  n_init;
    bit  got;
    rst_n_i    = 1'b0;
    req_i      = '0;
    req_data_i = '0;
    mode       = 2'd0;
    force_done = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_gnt",   gnt_o, 0);
    chk("rst_ack",   ack_o, 0);
    chk("rst_err",   err_o, 0);
    chk("rst_rsp",   rsp_data_o, 0);
    chk("rst_busy",  busy_o, 0);
    chk("rst_init",  conv_init_o, 0);
    chk("rst_cdata", conv_data_o, 0);
    rst_n_i = 1'b1;

    // Single request, registered converter
    mode = 2'd2;
    req_data_i[1*WIDTH +: WIDTH] = 8'hB6;
    @(negedge clk_i);
    req_i = 4'b0010;
    @(negedge clk_i);
    chk("t1_gnt",   gnt_o, 4'b0010);
    chk("t1_init",  conv_init_o, 1);
    chk("t1_cdata", conv_data_o, 8'hB6);
    @(negedge clk_i);
    chk("t1_ack_c2", ack_o, 0);
    chk("t1_busy_c2", busy_o, 1);
    @(negedge clk_i);
    chk("t1_ack", ack_o, 4'b0010);
    chk("t1_rsp", rsp_data_o, 8'hDB);
    chk("t1_err", err_o, 0);
    req_i = '0;

    // Same request, combinational converter
    mode = 2'd1;
    @(negedge clk_i);
    req_i = 4'b0010;
    @(negedge clk_i);
    chk("t2_gnt",  gnt_o, 4'b0010);
    chk("t2_init", conv_init_o, 1);
    @(negedge clk_i);
    chk("t2_ack", ack_o, 4'b0010);
    chk("t2_rsp", rsp_data_o, 8'hDB);
    req_i = '0;
    @(negedge clk_i);
    chk("t2_init_gone", conv_init_o, 0);

    // All four requesters held high, from fresh priority
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    req_data_i = {8'h02, 8'h03, 8'h01, 8'h00};
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n_init = 0;
      got    = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        @(negedge clk_i);
        if (conv_init_o) n_init++;
        if (ack_o != 0) got = 1'b1;
      end
      chk("t3_got_ack", got, 1);
      chk("t3_ack", ack_o, exp_own[k]);
      chk("t3_gnt", gnt_o, exp_own[k]);
      chk("t3_rsp", rsp_data_o, exp_rsp[k]);
      chk("t3_ninit", n_init, 1);
    end
    req_i = '0;

    // Watchdog with a silent converter
    mode = 2'd0;
    @(negedge clk_i);
    req_i = 4'b0010;
    repeat (16) @(negedge clk_i);
    chk("t4_ack_c16",  ack_o, 0);
    chk("t4_busy_c16", busy_o, 1);
    @(negedge clk_i);
    chk("t4_ack", ack_o, 4'b0010);
    chk("t4_err", err_o, 1);
    chk("t4_rsp", rsp_data_o, 0);
    req_i = '0;
    @(negedge clk_i);
    force_done = 1'b1;
    chk("t4_busy_c18", busy_o, 0);
    @(negedge clk_i);
    force_done = 1'b0;
    chk("t4_late_ack",  ack_o, 0);
    chk("t4_late_busy", busy_o, 0);
    chk("t4_late_rsp",  rsp_data_o, 0);

    // Reset asserted mid-WAIT
    req_data_i[2*WIDTH +: WIDTH] = 8'h55;
    req_i = 4'b0100;
    @(negedge clk_i);
    chk("t5_gnt_c1", gnt_o, 4'b0100);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("t5_rst_gnt",   gnt_o, 0);
    chk("t5_rst_busy",  busy_o, 0);
    chk("t5_rst_ack",   ack_o, 0);
    chk("t5_rst_init",  conv_init_o, 0);
    chk("t5_rst_cdata", conv_data_o, 0);
    req_i = 4'b1001;
    req_data_i[0 +: WIDTH] = 8'h80;
    mode = 2'd1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("t5_gnt", gnt_o, 4'b0001);
    @(negedge clk_i);
    chk("t5_ack", ack_o, 4'b0001);
    chk("t5_rsp", rsp_data_o, 8'hFF);
    req_i = '0;

    // Spurious done while idle
    @(negedge clk_i);
    force_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("t6_ack",  ack_o, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_rsp",  rsp_data_o, 8'hFF);
    end
    force_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
